// File: rtl/moesi_pkg.sv
// Shared MOESI encodings, response-source codes and controller FSM states.
// Latency: none, declarations only.
// Backpressure: not applicable.
package moesi_pkg;

  localparam int MAX_PROC = 16;

  typedef enum logic [2:0] {
    ST_I = 3'b000,
    ST_S = 3'b001,
    ST_E = 3'b010,
    ST_O = 3'b011,
    ST_M = 3'b100
  } moesi_t;

  typedef enum logic [1:0] {
    SRC_HIT = 2'b00,
    SRC_MEM = 2'b01,
    SRC_C2C = 2'b10
  } src_t;

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_LOOKUP,
    FSM_INVAL,
    FSM_MEM,
    FSM_RESP
  } fsm_t;

  // Number of set bits in an invalidation mask (at most MAX_PROC wide).
  function automatic logic [4:0] popcnt16(input logic [MAX_PROC-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < MAX_PROC; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/moesi_line_next.sv
// Next directory row for one line given a requester and op, plus invalidation mask.
// Latency: purely combinational.
// Backpressure: none, evaluated whenever the row or request changes.
module moesi_line_next
  import moesi_pkg::*;
#(
  parameter int NUM_PROC = 4,
  parameter int PID_W    = 2
) (
  input  logic [3*NUM_PROC-1:0] row,
  input  logic [PID_W-1:0]      proc,
  input  logic                  write,
  output logic [3*NUM_PROC-1:0] nxt_row,
  output logic [NUM_PROC-1:0]   inv_mask,
  output logic [2:0]            fin_state,
  output logic [1:0]            src,
  output logic                  fetch,
  output logic                  err
);

  logic [2:0] my_st;
  logic       owner_hit;
  logic       any_other;

  // Summarise the row: requester's own state and what the other processors hold.
  always_comb begin
    err       = (int'(proc) >= NUM_PROC);
    my_st     = ST_I;
    owner_hit = 1'b0;
    any_other = 1'b0;
    for (int p = 0; p < NUM_PROC; p++) begin
      if (p == int'(proc)) begin
        my_st = row[3*p +: 3];
      end else if (row[3*p +: 3] != ST_I) begin
        any_other = 1'b1;
        if (row[3*p +: 3] inside {ST_E, ST_O, ST_M}) owner_hit = 1'b1;
      end
    end
  end

  // Apply the MOESI transition; an out-of-range requester leaves the row untouched.
  always_comb begin
    nxt_row   = row;
    inv_mask  = '0;
    fin_state = ST_I;
    src       = SRC_HIT;
    fetch     = 1'b0;
    if (!err) begin
      if (!write) begin
        if (my_st != ST_I) begin
          fin_state = my_st;
        end else begin
          fin_state = any_other ? ST_S : ST_E;
          src       = owner_hit ? SRC_C2C : SRC_MEM;
          fetch     = !owner_hit;
          // The supplier downgrades: M keeps ownership as O, E drops to S.
          for (int p = 0; p < NUM_PROC; p++) begin
            if (p != int'(proc)) begin
              if (row[3*p +: 3] == ST_M)      nxt_row[3*p +: 3] = ST_O;
              else if (row[3*p +: 3] == ST_E) nxt_row[3*p +: 3] = ST_S;
            end
          end
        end
      end else begin
        fin_state = ST_M;
        for (int p = 0; p < NUM_PROC; p++) begin
          if (p != int'(proc) && row[3*p +: 3] != ST_I) begin
            inv_mask[p]       = 1'b1;
            nxt_row[3*p +: 3] = ST_I;
          end
        end
        if (my_st == ST_I) begin
          src   = owner_hit ? SRC_C2C : SRC_MEM;
          fetch = !owner_hit;
        end
      end
      for (int p = 0; p < NUM_PROC; p++) begin
        if (p == int'(proc)) nxt_row[3*p +: 3] = fin_state;
      end
    end
  end

endmodule

// File: rtl/moesi_directory_ctrl.sv
// MOESI directory controller: serial requests against a per-line, per-processor state table.
// Latency: response 1 + invalidations + (MEM_LAT when fetching) cycles after acceptance.
// Backpressure: req_ready only while idle; response held stable until resp_ready.
module moesi_directory_ctrl
  import moesi_pkg::*;
#(
  parameter  int NUM_PROC  = 4,
  parameter  int NUM_LINES = 8,
  parameter  int MEM_LAT   = 3,
  localparam int PID_W     = (NUM_PROC > 2) ? $clog2(NUM_PROC) : 1,
  localparam int LINE_W    = $clog2(NUM_LINES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PID_W-1:0]      req_proc,
  input  logic [LINE_W-1:0]     req_line,
  input  logic                  req_write,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [PID_W-1:0]      resp_proc,
  output logic [LINE_W-1:0]     resp_line,
  output logic [2:0]            resp_state,
  output logic [1:0]            resp_src,
  output logic [4:0]            resp_inv_cnt,
  output logic                  resp_err,
  input  logic [LINE_W-1:0]     qry_line,
  output logic [3*NUM_PROC-1:0] qry_states
);

  localparam logic [4:0] MEM_CNT = 5'(MEM_LAT - 1);

  fsm_t                  state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [PID_W-1:0]      cur_proc_q, cur_proc_d;
  logic [LINE_W-1:0]     cur_line_q, cur_line_d;
  logic                  cur_write_q, cur_write_d;
  logic [PID_W-1:0]      resp_proc_q, resp_proc_d;
  logic [LINE_W-1:0]     resp_line_q, resp_line_d;
  logic [2:0]            resp_state_q, resp_state_d;
  logic [1:0]            resp_src_q, resp_src_d;
  logic [4:0]            resp_inv_cnt_q, resp_inv_cnt_d;
  logic                  resp_err_q, resp_err_d;
  logic [3*NUM_PROC-1:0] dir_q [NUM_LINES];
  logic [3*NUM_PROC-1:0] dir_d [NUM_LINES];

  logic [3*NUM_PROC-1:0] cur_row, ln_row;
  logic [NUM_PROC-1:0]   ln_mask;
  logic [MAX_PROC-1:0]   mask16;
  logic [4:0]            inv_cnt;
  logic [2:0]            ln_fin;
  logic [1:0]            ln_src;
  logic                  ln_fetch, ln_err, commit;

  assign cur_row    = dir_q[cur_line_q];
  assign qry_states = dir_q[qry_line];

  moesi_line_next #(.NUM_PROC(NUM_PROC), .PID_W(PID_W)) u_line_next (
    .row       (cur_row),
    .proc      (cur_proc_q),
    .write     (cur_write_q),
    .nxt_row   (ln_row),
    .inv_mask  (ln_mask),
    .fin_state (ln_fin),
    .src       (ln_src),
    .fetch     (ln_fetch),
    .err       (ln_err)
  );

  // Invalidation count: one INVAL cycle per processor losing its copy.
  always_comb begin
    mask16                 = '0;
    mask16[NUM_PROC-1:0]   = ln_mask;
    inv_cnt                = popcnt16(mask16);
  end

  // FSM state register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FSM_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state and phase counter (counts down to zero within INVAL/MEM).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FSM_IDLE:   if (req_valid) state_d = FSM_LOOKUP;
      FSM_LOOKUP: begin
        if (inv_cnt != 5'd0) begin
          state_d = FSM_INVAL;
          cnt_d   = inv_cnt - 5'd1;
        end else if (ln_fetch) begin
          state_d = FSM_MEM;
          cnt_d   = MEM_CNT;
        end else begin
          state_d = FSM_RESP;
        end
      end
      FSM_INVAL: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else if (ln_fetch) begin
          state_d = FSM_MEM;
          cnt_d   = MEM_CNT;
        end else begin
          state_d = FSM_RESP;
        end
      end
      FSM_MEM: begin
        if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
        else               state_d = FSM_RESP;
      end
      FSM_RESP:   if (resp_ready) state_d = FSM_IDLE;
      default:    state_d = FSM_IDLE;
    endcase
  end

  // FSM outputs; ready is also held low while reset is asserted.
  always_comb begin
    req_ready    = reset_n && (state_q == FSM_IDLE);
    resp_valid   = (state_q == FSM_RESP);
    resp_proc    = resp_proc_q;
    resp_line    = resp_line_q;
    resp_state   = resp_state_q;
    resp_src     = resp_src_q;
    resp_inv_cnt = resp_inv_cnt_q;
    resp_err     = resp_err_q;
  end

  // Capture the request, and commit row + response together on entry to RESP.
  always_comb begin
    commit         = (state_d == FSM_RESP) && (state_q != FSM_RESP);
    cur_proc_d     = cur_proc_q;
    cur_line_d     = cur_line_q;
    cur_write_d    = cur_write_q;
    resp_proc_d    = resp_proc_q;
    resp_line_d    = resp_line_q;
    resp_state_d   = resp_state_q;
    resp_src_d     = resp_src_q;
    resp_inv_cnt_d = resp_inv_cnt_q;
    resp_err_d     = resp_err_q;
    dir_d          = dir_q;
    if (state_q == FSM_IDLE && req_valid) begin
      cur_proc_d  = req_proc;
      cur_line_d  = req_line;
      cur_write_d = req_write;
    end
    if (commit) begin
      resp_proc_d         = cur_proc_q;
      resp_line_d         = cur_line_q;
      resp_state_d        = ln_fin;
      resp_src_d          = ln_src;
      resp_inv_cnt_d      = inv_cnt;
      resp_err_d          = ln_err;
      dir_d[cur_line_q]   = ln_row;
    end
  end

  // Datapath and directory registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      cur_proc_q     <= '0;
      cur_line_q     <= '0;
      cur_write_q    <= 1'b0;
      resp_proc_q    <= '0;
      resp_line_q    <= '0;
      resp_state_q   <= '0;
      resp_src_q     <= '0;
      resp_inv_cnt_q <= '0;
      resp_err_q     <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) dir_q[i] <= '0;
    end else begin
      cnt_q          <= cnt_d;
      cur_proc_q     <= cur_proc_d;
      cur_line_q     <= cur_line_d;
      cur_write_q    <= cur_write_d;
      resp_proc_q    <= resp_proc_d;
      resp_line_q    <= resp_line_d;
      resp_state_q   <= resp_state_d;
      resp_src_q     <= resp_src_d;
      resp_inv_cnt_q <= resp_inv_cnt_d;
      resp_err_q     <= resp_err_d;
      for (int i = 0; i < NUM_LINES; i++) dir_q[i] <= dir_d[i];
    end
  end

endmodule

// File: tb/tb_moesi_directory_ctrl.sv
// Bench for moesi_directory_ctrl: behavioural directory model with per-cycle compare.
// Latency: model counts 1 + k + fetch*MEM_LAT edges from acceptance to response.
// Backpressure: bench holds resp_ready low to exercise stall and request queuing.
module tb_moesi_directory_ctrl;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_proc;
  logic [2:0]  req_line;
  logic        resp_valid, resp_ready, resp_err;
  logic [1:0]  resp_proc, resp_src;
  logic [2:0]  resp_line, resp_state;
  logic [4:0]  resp_inv_cnt;
  logic [2:0]  qry_line;
  logic [11:0] qry_states;

  // Second instance with three processors so that an out-of-range ID is encodable.
  logic        d3_req_valid, d3_req_ready, d3_req_write;
  logic [1:0]  d3_req_proc;
  logic [2:0]  d3_req_line;
  logic        d3_resp_valid, d3_resp_ready, d3_resp_err;
  logic [1:0]  d3_resp_proc, d3_resp_src;
  logic [2:0]  d3_resp_line, d3_resp_state;
  logic [4:0]  d3_resp_inv_cnt;
  logic [2:0]  d3_qry_line;
  logic [8:0]  d3_qry_states;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  moesi_directory_ctrl #(.NUM_PROC(4), .NUM_LINES(8), .MEM_LAT(MEM_LAT)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_proc(req_proc),
    .req_line(req_line), .req_write(req_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_proc(resp_proc),
    .resp_line(resp_line), .resp_state(resp_state), .resp_src(resp_src),
    .resp_inv_cnt(resp_inv_cnt), .resp_err(resp_err),
    .qry_line(qry_line), .qry_states(qry_states)
  );

  moesi_directory_ctrl #(.NUM_PROC(3), .NUM_LINES(8), .MEM_LAT(MEM_LAT)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_proc(d3_req_proc),
    .req_line(d3_req_line), .req_write(d3_req_write),
    .resp_valid(d3_resp_valid), .resp_ready(d3_resp_ready), .resp_proc(d3_resp_proc),
    .resp_line(d3_resp_line), .resp_state(d3_resp_state), .resp_src(d3_resp_src),
    .resp_inv_cnt(d3_resp_inv_cnt), .resp_err(d3_resp_err),
    .qry_line(d3_qry_line), .qry_states(d3_qry_states)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0]  fin;
    logic [1:0]  src;
    logic [4:0]  k;
    logic        fetch;
    logic [11:0] row;
  } outc_t;

  // MOESI rules per processor: I=0 S=1 E=2 O=3 M=4; src HIT=0 MEM=1 C2C=2.
  function automatic outc_t model_req(input logic [11:0] row, input int p, input bit wr);
    outc_t o;
    int me, own, others, st;
    o.row = row; o.k = '0; o.fetch = 1'b0; o.src = 2'd0; o.fin = 3'd0;
    me = int'(row[3*p +: 3]);
    own = -1; others = 0;
    for (int q = 0; q < 4; q++) begin
      st = int'(row[3*q +: 3]);
      if (q != p && st != 0) begin
        others++;
        if (st >= 2) own = q;
      end
    end
    if (!wr) begin
      if (me != 0) begin
        o.fin = 3'(me);
      end else if (own < 0) begin
        o.fin = (others > 0) ? 3'd1 : 3'd2;
        o.src = 2'd1; o.fetch = 1'b1;
      end else begin
        o.fin = 3'd1; o.src = 2'd2;
        st = int'(row[3*own +: 3]);
        if (st == 4)      o.row[3*own +: 3] = 3'd3;
        else if (st == 2) o.row[3*own +: 3] = 3'd1;
      end
    end else begin
      o.fin = 3'd4;
      o.k = 5'(others);
      for (int q = 0; q < 4; q++) if (q != p) o.row[3*q +: 3] = 3'd0;
      if (me == 0) begin
        o.src   = (own >= 0) ? 2'd2 : 2'd1;
        o.fetch = (own < 0);
      end
    end
    o.row[3*p +: 3] = o.fin;
    return o;
  endfunction

  bit          m_busy, m_inresp;
  int          m_cnt;
  outc_t       m_out, mdl_nx;
  logic [1:0]  m_proc;
  logic [2:0]  m_line;
  logic [11:0] mrow [8];

  always_comb mdl_nx = model_req(mrow[req_line], int'(req_proc), req_write);

  // Model timeline: accept when idle, respond after the computed latency, retire on handshake.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_inresp <= 1'b0; m_cnt <= 0;
      for (int l = 0; l < 8; l++) mrow[l] <= '0;
    end else if (!m_busy && !m_inresp) begin
      if (req_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 1 + int'(mdl_nx.k) + (mdl_nx.fetch ? MEM_LAT : 0);
        m_out  <= mdl_nx;
        m_proc <= req_proc;
        m_line <= req_line;
      end
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy   <= 1'b0;
        m_inresp <= 1'b1;
        mrow[m_line] <= m_out.row;
      end
      m_cnt <= m_cnt - 1;
    end else if (resp_ready) begin
      m_inresp <= 1'b0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_req_ready", req_ready, reset_n && !m_busy && !m_inresp);
    chk("cmp_resp_valid", resp_valid, m_inresp);
    if (!reset_n) begin
      chk("cmp_rst_resp", {resp_proc, resp_line, resp_state, resp_src, resp_inv_cnt, resp_err}, 0);
    end else if (resp_valid && m_inresp) begin
      chk("cmp_resp_proc", resp_proc, m_proc);
      chk("cmp_resp_line", resp_line, m_line);
      chk("cmp_resp_state", resp_state, m_out.fin);
      chk("cmp_resp_src", resp_src, m_out.src);
      chk("cmp_resp_inv", resp_inv_cnt, m_out.k);
      chk("cmp_resp_err", resp_err, 0);
    end
    chk("cmp_qry", qry_states, mrow[qry_line]);
  end

  // ---------------- directed stimulus ----------------
  // Called just after a rising edge; returns just after the handshake edge.
  task automatic do_req(input int p, input int l, input bit w, input int hold,
                        input bit q_en, input int qp, input int ql, input bit qw,
                        output int lat, output logic [2:0] st, output logic [1:0] sr,
                        output logic [4:0] iv, output logic [11:0] qs);
    int guard;
    req_proc = 2'(p); req_line = 3'(l); req_write = w; req_valid = 1'b1;
    qry_line = 3'(l); resp_ready = (hold == 0);
    guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) chk("resp_timeout", 0, 1);
    st = resp_state; sr = resp_src; iv = resp_inv_cnt; qs = qry_states;
    if (hold > 0) begin
      if (q_en) begin
        req_proc = 2'(qp); req_line = 3'(ql); req_write = qw; req_valid = 1'b1;
      end
      repeat (hold) begin
        @(posedge clk); #1;
        chk("bp_req_ready", req_ready, 0);
        chk("bp_resp_valid", resp_valid, 1);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_resp(input string tag, input int lat, input logic [2:0] st,
                             input logic [1:0] sr, input logic [4:0] iv, input logic [11:0] qs,
                             input int e_lat, input logic [2:0] e_st, input logic [1:0] e_sr,
                             input logic [4:0] e_iv, input logic [11:0] e_qs);
    chk($sformatf("%s_latency", tag), lat, e_lat);
    chk($sformatf("%s_state", tag), st, e_st);
    chk($sformatf("%s_src", tag), sr, e_sr);
    chk($sformatf("%s_inv", tag), iv, e_iv);
    chk($sformatf("%s_qry", tag), qs, e_qs);
  endtask

  initial begin
    int lat;
    logic [2:0] st;
    logic [1:0] sr;
    logic [4:0] iv;
    logic [11:0] qs;
    reset_n = 1'b0; req_valid = 1'b0; req_proc = '0; req_line = '0; req_write = 1'b0;
    resp_ready = 1'b1; qry_line = '0;
    d3_req_valid = 1'b0; d3_req_proc = '0; d3_req_line = '0; d3_req_write = 1'b0;
    d3_resp_ready = 1'b1; d3_qry_line = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_qry", qry_states, 12'h000);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 1);

    // Read miss, no sharers: E from memory.
    do_req(0, 2, 0, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("p0_rd_l2", lat, st, sr, iv, qs, 4, 3'b010, 2'b01, 5'd0, 12'h002);
    // Write hit in E: silent upgrade to M.
    do_req(0, 2, 1, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("p0_wr_l2", lat, st, sr, iv, qs, 1, 3'b100, 2'b00, 5'd0, 12'h004);
    // Read miss with M owner: owner to O, requester S via cache-to-cache.
    do_req(1, 2, 0, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("p1_rd_l2", lat, st, sr, iv, qs, 1, 3'b001, 2'b10, 5'd0, 12'h00B);
    // Read miss with O owner: owner stays O.
    do_req(2, 2, 0, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("p2_rd_l2", lat, st, sr, iv, qs, 1, 3'b001, 2'b10, 5'd0, 12'h04B);
    // Write from S with O and S peers: two invalidations.
    do_req(1, 2, 1, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("p1_wr_l2", lat, st, sr, iv, qs, 3, 3'b100, 2'b00, 5'd2, 12'h020);
    // Backpressure for 5 cycles with a queued write behind it.
    do_req(2, 2, 0, 5, 1, 3, 5, 1, lat, st, sr, iv, qs);
    expect_resp("bp_p2_rd_l2", lat, st, sr, iv, qs, 1, 3'b001, 2'b10, 5'd0, 12'h058);
    do_req(3, 5, 1, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("queued_p3_wr_l5", lat, st, sr, iv, qs, 4, 3'b100, 2'b01, 5'd0, 12'h800);
    // Read hit in O.
    do_req(1, 2, 0, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("p1_rdhit_l2", lat, st, sr, iv, qs, 1, 3'b011, 2'b00, 5'd0, 12'h058);

    // Reset during the memory phase: no response, directory cleared.
    req_proc = 2'd0; req_line = 3'd3; req_write = 1'b0; req_valid = 1'b1; qry_line = 3'd3;
    chk("abort_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_resp", resp_valid, 0);
      chk("abort_ready_low", req_ready, 0);
    end
    reset_n = 1'b1;
    #1;
    chk("abort_ready_after", req_ready, 1);
    for (int l = 0; l < 8; l++) begin
      @(posedge clk); #1;
      qry_line = 3'(l);
      #1;
      chk($sformatf("abort_line%0d_clear", l), qry_states, 12'h000);
      chk("abort_no_resp_after", resp_valid, 0);
    end

    // Line independence and sharer-only miss paths on line 7.
    do_req(0, 7, 0, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("p0_rd_l7", lat, st, sr, iv, qs, 4, 3'b010, 2'b01, 5'd0, 12'h002);
    do_req(1, 7, 0, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("p1_rd_l7", lat, st, sr, iv, qs, 1, 3'b001, 2'b10, 5'd0, 12'h009);
    do_req(3, 0, 1, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("p3_wr_l0", lat, st, sr, iv, qs, 4, 3'b100, 2'b01, 5'd0, 12'h800);
    qry_line = 3'd7;
    #1;
    chk("l7_untouched", qry_states, 12'h009);
    do_req(3, 7, 0, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("p3_rd_l7_shared", lat, st, sr, iv, qs, 4, 3'b001, 2'b01, 5'd0, 12'h209);
    do_req(2, 7, 1, 0, 0, 0, 0, 0, lat, st, sr, iv, qs);
    expect_resp("p2_wr_l7_fetch", lat, st, sr, iv, qs, 7, 3'b100, 2'b01, 5'd3, 12'h100);

    // Out-of-range requester on the three-processor instance.
    d3_req_proc = 2'd3; d3_req_line = 3'd1; d3_req_write = 1'b1; d3_qry_line = 3'd1;
    d3_req_valid = 1'b1;
    chk("err_ready", d3_req_ready, 1);
    @(posedge clk); #1;
    d3_req_valid = 1'b0;
    lat = 0;
    while (!d3_resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("err_latency", lat, 1);
    chk("err_flag", d3_resp_err, 1);
    chk("err_state", d3_resp_state, 3'b000);
    chk("err_src", d3_resp_src, 2'b00);
    chk("err_inv", d3_resp_inv_cnt, 5'd0);
    chk("err_echo", {d3_resp_proc, d3_resp_line}, {2'd3, 3'd1});
    chk("err_qry", d3_qry_states, 9'h000);
    @(posedge clk); #1;
    chk("err_back_idle", d3_req_ready, 1);
    chk("err_no_resp", d3_resp_valid, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
